cp0_irq_timer: RTL and testbench

Parametrised CP0 register block for the OpenMIPS core. It holds Count, Compare, Status, Cause and EPC, with a configurable number of hardware interrupt lines, an input synchroniser and a Count prescaler. It produces the interrupt request to the pipeline and records exception entry and return (EPC/EXL). It sits beside the MEM/WB stage and is reached by mtc0/mfc0 through a register-address port.

---
 rtl/cp0_irq_timer.sv | 174 +++++++++++++++++
 tb/tb_cp0_irq_timer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_irq_timer.sv
// CP0 register block for OpenMIPS: Count/Compare timer, Status, Cause, EPC,
// synchronised hardware interrupts and the interrupt request to the pipeline.
module cp0_irq_timer #(
    parameter int NUM_HW_IRQ  = 6,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_DIV   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [4:0]            raddr_i,
    output logic [31:0]           rdata_o,
    input  logic [NUM_HW_IRQ-1:0] int_i,
    input  logic                  exc_en_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_epc_i,
    input  logic                  eret_i,
    output logic [31:0]           count_o,
    output logic [31:0]           compare_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  timer_int_o,
    output logic                  irq_req_o
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    localparam int            PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic [31:0]           epc_q, epc_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [7:0]            im_q, im_d;
    logic                  exl_q, exl_d;
    logic                  ie_q, ie_d;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic [4:0]            exc_code_q, exc_code_d;
    logic                  timer_int_q, timer_int_d;
    logic                  armed_q, armed_d;
    logic [NUM_HW_IRQ-1:0] sync_q [SYNC_STAGES];

    logic       wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [5:0] hw_ip;
    logic [7:0] ip;

    assign wr_count   = we_i && (waddr_i == REG_COUNT);
    assign wr_compare = we_i && (waddr_i == REG_COMPARE);
    assign wr_status  = we_i && (waddr_i == REG_STATUS);
    assign wr_cause   = we_i && (waddr_i == REG_CAUSE);
    assign wr_epc     = we_i && (waddr_i == REG_EPC);

    always_comb begin
        hw_ip                   = '0;
        hw_ip[NUM_HW_IRQ-1:0]   = sync_q[SYNC_STAGES-1];
    end

    // IP7 is shared between the last hardware line and the timer.
    assign ip = {hw_ip[5] | timer_int_q, hw_ip[4:0], ip_sw_q};

    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred; later statements express priority by overriding.
    always_comb begin
        count_d     = count_q;
        presc_d     = presc_q;
        compare_d   = compare_q;
        timer_int_d = timer_int_q;
        armed_d     = armed_q;
        im_d        = im_q;
        ie_d        = ie_q;
        exl_d       = exl_q;
        ip_sw_d     = ip_sw_q;
        exc_code_d  = exc_code_q;
        epc_d       = epc_q;

        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            count_d = count_q + 32'd1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
        if (wr_count) begin
            count_d = wdata_i;
            presc_d = '0;
        end

        if (armed_q && (count_q == compare_q))
            timer_int_d = 1'b1;
        if (wr_compare) begin
            compare_d   = wdata_i;
            timer_int_d = 1'b0;
            armed_d     = 1'b1;
        end

        if (wr_status) begin
            im_d  = wdata_i[15:8];
            ie_d  = wdata_i[0];
            exl_d = wdata_i[1];
        end
        if (wr_cause)
            ip_sw_d = wdata_i[9:8];
        if (wr_epc)
            epc_d = wdata_i;

        if (eret_i)
            exl_d = 1'b0;
        if (exc_en_i) begin
            exl_d      = 1'b1;
            epc_d      = exc_epc_i;
            exc_code_d = exc_code_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            presc_q     <= '0;
            compare_q   <= '0;
            timer_int_q <= 1'b0;
            armed_q     <= 1'b0;
            im_q        <= '0;
            ie_q        <= 1'b0;
            exl_q       <= 1'b0;
            ip_sw_q     <= '0;
            exc_code_q  <= '0;
            epc_q       <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            count_q     <= count_d;
            presc_q     <= presc_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
            armed_q     <= armed_d;
            im_q        <= im_d;
            ie_q        <= ie_d;
            exl_q       <= exl_d;
            ip_sw_q     <= ip_sw_d;
            exc_code_q  <= exc_code_d;
            epc_q       <= epc_d;
            sync_q[0]   <= int_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = {16'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_o     = {1'b0, timer_int_q, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
    assign epc_o       = epc_q;
    assign timer_int_o = timer_int_q;
    assign irq_req_o   = ie_q & ~exl_q & (|(ip & im_q));

    always_comb begin
        case (raddr_i)
            REG_COUNT:   rdata_o = count_o;
            REG_COMPARE: rdata_o = compare_o;
            REG_STATUS:  rdata_o = status_o;
            REG_CAUSE:   rdata_o = cause_o;
            REG_EPC:     rdata_o = epc_o;
            default:     rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Randomised and directed bench for cp0_irq_timer, checked every cycle against
// a register-level behavioural model of the CP0 block.
module tb_cp0_irq_timer;

    localparam int NUM_HW_IRQ  = 6;
    localparam int SYNC_STAGES = 2;
    localparam int COUNT_DIV   = 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  we_i;
    logic [4:0]            waddr_i;
    logic [31:0]           wdata_i;
    logic [4:0]            raddr_i;
    logic [31:0]           rdata_o;
    logic [NUM_HW_IRQ-1:0] int_i;
    logic                  exc_en_i;
    logic [4:0]            exc_code_i;
    logic [31:0]           exc_epc_i;
    logic                  eret_i;
    logic [31:0]           count_o, compare_o, status_o, cause_o, epc_o;
    logic                  timer_int_o, irq_req_o;

    int checks   = 0;
    int failures = 0;

    cp0_irq_timer #(
        .NUM_HW_IRQ (NUM_HW_IRQ),
        .SYNC_STAGES(SYNC_STAGES),
        .COUNT_DIV  (COUNT_DIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .raddr_i    (raddr_i),
        .rdata_o    (rdata_o),
        .int_i      (int_i),
        .exc_en_i   (exc_en_i),
        .exc_code_i (exc_code_i),
        .exc_epc_i  (exc_epc_i),
        .eret_i     (eret_i),
        .count_o    (count_o),
        .compare_o  (compare_o),
        .status_o   (status_o),
        .cause_o    (cause_o),
        .epc_o      (epc_o),
        .timer_int_o(timer_int_o),
        .irq_req_o  (irq_req_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Count is kept as "value loaded + elapsed edges / COUNT_DIV".
    logic [31:0]           m_base = '0;
    int unsigned           m_n = 0;
    logic [31:0]           m_compare = '0, m_epc = '0;
    logic [7:0]            m_im = '0;
    logic                  m_ie = 0, m_exl = 0, m_ti = 0, m_armed = 0;
    logic [1:0]            m_ipsw = '0;
    logic [4:0]            m_code = '0;
    logic [NUM_HW_IRQ-1:0] m_hist[$];

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_n / COUNT_DIV);
    endfunction

    function automatic logic [7:0] m_ip();
        logic [7:0] ip;
        logic [7:0] hw;
        hw = '0;
        if (m_hist.size() >= SYNC_STAGES) hw[NUM_HW_IRQ-1:0] = m_hist[SYNC_STAGES-1];
        ip = {hw[7:2] << 0, m_ipsw} | (8'(hw) << 2);
        ip[7:2] = 6'(hw);
        ip[1:0] = m_ipsw;
        if (m_ti) ip[7] = 1'b1;
        return ip;
    endfunction

    function automatic logic [31:0] m_status();
        return (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_base = '0; m_n = 0; m_compare = '0; m_epc = '0; m_im = '0;
            m_ie = 0; m_exl = 0; m_ti = 0; m_armed = 0; m_ipsw = '0; m_code = '0;
            m_hist.delete();
        end else begin
            logic [31:0] cnt_now;
            cnt_now = m_count();
            if (we_i && waddr_i == 5'd11) begin
                m_compare = wdata_i; m_ti = 0; m_armed = 1;
            end else if (m_armed && cnt_now == m_compare) begin
                m_ti = 1;
            end
            if (we_i && waddr_i == 5'd9) begin
                m_base = wdata_i; m_n = 0;
            end else begin
                m_n++;
            end
            if (we_i && waddr_i == 5'd12) begin
                m_im = wdata_i[15:8]; m_ie = wdata_i[0];
            end
            if (exc_en_i) m_exl = 1;
            else if (eret_i) m_exl = 0;
            else if (we_i && waddr_i == 5'd12) m_exl = wdata_i[1];
            if (we_i && waddr_i == 5'd13) m_ipsw = wdata_i[9:8];
            if (exc_en_i) begin
                m_code = exc_code_i; m_epc = exc_epc_i;
            end else if (we_i && waddr_i == 5'd14) begin
                m_epc = wdata_i;
            end
            m_hist.push_front(int_i);
            if (m_hist.size() > SYNC_STAGES) void'(m_hist.pop_back());
        end
    end

    always @(negedge clk) begin
        logic irq;
        irq = m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
        check("count",     count_o,     m_count());
        check("compare",   compare_o,   m_compare);
        check("status",    status_o,    m_status());
        check("cause",     cause_o,     m_cause());
        check("epc",       epc_o,       m_epc);
        check("timer_int", 32'(timer_int_o), 32'(m_ti));
        check("irq_req",   32'(irq_req_o),   32'(irq));
        check("rdata",     rdata_o,     m_read(raddr_i));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        idle(1);
        we_i = 1'b0;
    endtask

    initial begin
        logic [4:0] addr_tab [8];
        addr_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31, 5'd10};
        reset_n = 1'b0; we_i = 0; waddr_i = '0; wdata_i = '0; raddr_i = 5'd9;
        int_i = '0; exc_en_i = 0; exc_code_i = '0; exc_epc_i = '0; eret_i = 0;

        // Reset and free-running Count.
        idle(3);
        @(negedge clk);
        check("rst_count", count_o, 32'd0);
        check("rst_cause", cause_o, 32'd0);
        idle(1);
        reset_n = 1'b1;
        idle(50);
        @(negedge clk);
        check("count_after_50", count_o, 32'd25);
        check("no_spurious_ti", 32'(timer_int_o), 32'd0);

        // Wrap with the prescaler.
        mtc0(5'd9, 32'hFFFF_FFFE);
        idle(2);
        @(negedge clk);
        check("count_pre_wrap", count_o, 32'hFFFF_FFFF);
        idle(2);
        @(negedge clk);
        check("count_wrap", count_o, 32'h0000_0000);

        // Timer match and clear.
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd10);
        mtc0(5'd12, 32'h0000_8001);
        begin
            bit found = 0;
            for (int i = 0; i < 200 && !found; i++) begin
                @(negedge clk);
                if (count_o == 32'd20) found = 1;
            end
            check("wait_count20", 32'(found), 32'd1);
        end
        check("ti_not_yet", 32'(timer_int_o), 32'd0);
        idle(1);
        @(negedge clk);
        check("ti_set", 32'(timer_int_o), 32'd1);
        check("cause_ti_ip7", cause_o & 32'h4000_8000, 32'h4000_8000);
        check("irq_timer", 32'(irq_req_o), 32'd1);
        mtc0(5'd11, 32'd100);
        @(negedge clk);
        check("ti_cleared", 32'(timer_int_o), 32'd0);

        // Hardware interrupt through the synchroniser.
        mtc0(5'd12, 32'h0000_0401);
        int_i[0] = 1'b1;
        idle(1);
        @(negedge clk);
        check("ip2_one_stage", cause_o[10], 1'b0);
        idle(1);
        @(negedge clk);
        check("ip2_synced", 32'(cause_o[10]), 32'd1);
        check("irq_hw", 32'(irq_req_o), 32'd1);
        mtc0(5'd12, 32'h0000_0400);
        @(negedge clk);
        check("irq_ie0", 32'(irq_req_o), 32'd0);

        // Exception entry and eret.
        mtc0(5'd12, 32'h0000_0401);
        exc_en_i = 1; exc_code_i = 5'h08; exc_epc_i = 32'hBFC0_0100;
        idle(1);
        exc_en_i = 0;
        @(negedge clk);
        check("epc", epc_o, 32'hBFC0_0100);
        check("exl_set", 32'(status_o[1]), 32'd1);
        check("exccode", 32'(cause_o[6:2]), 32'd8);
        check("irq_masked_exl", 32'(irq_req_o), 32'd0);
        eret_i = 1;
        idle(1);
        eret_i = 0;
        @(negedge clk);
        check("exl_clr", 32'(status_o[1]), 32'd0);
        check("irq_after_eret", 32'(irq_req_o), 32'd1);

        // Priority collisions.
        exc_en_i = 1; eret_i = 1; exc_code_i = 5'h0C;
        mtc0(5'd12, 32'h0000_0000);
        exc_en_i = 0; eret_i = 0;
        @(negedge clk);
        check("prio_status", status_o, 32'h0000_0002);
        mtc0(5'd9, 32'd5);
        idle(1);
        mtc0(5'd9, 32'h0000_1234);
        @(negedge clk);
        check("count_write_wins", count_o, 32'h0000_1234);
        idle(2);
        @(negedge clk);
        check("count_after_write", count_o, 32'h0000_1235);

        // Randomised traffic with one mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            we_i      = ($urandom_range(0, 3) == 0);
            waddr_i   = addr_tab[$urandom_range(0, 7)];
            wdata_i   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            raddr_i   = addr_tab[$urandom_range(0, 7)];
            exc_en_i  = ($urandom_range(0, 15) == 0);
            eret_i    = ($urandom_range(0, 15) == 0);
            exc_code_i = 5'($urandom);
            exc_epc_i = $urandom;
            if ($urandom_range(0, 7) == 0) int_i = NUM_HW_IRQ'($urandom);
            if (c == 1500) reset_n = 1'b0;
            if (c == 1502) reset_n = 1'b1;
            idle(1);
        end
        we_i = 0; exc_en_i = 0; eret_i = 0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
